// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared encodings for the CPU / loader memory-port arbiter:
//                FSM state values and requester port identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_ACK  = 2'b10
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Width of the wait counter; covers WAIT values 1..15.
    localparam int c_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of both requester handshakes and the memory-side bus.
//                slave  = arbiter view, master = requesters + memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Port 0 (CPU)
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    // Port 1 (loader / debug DMA)
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    // Completion / status
    logic [DW-1:0] rdata;
    logic          busy;
    logic          gnt_id;
    // Memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata, busy, gnt_id,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata, busy, gnt_id,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one single-ported memory between
//                the multicycle CPU (port 0) and the loader/DMA (port 1).
//                Each grant holds the memory for WAIT cycles, then pulses the
//                winner's ack for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input wire clk,
    input wire rst,          // asynchronous, active-low
    mem_port_arbiter_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_WAIT_M1 = c_CNT_W'(WAIT - 1);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic               w_grant;
    logic               w_winner;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_gnt;
    logic               r_last;
    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_rdata;

    // Next-state and round-robin pick; a tie goes to the port that did not win last.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_winner     = PORT_CPU;
        case (r_state)
            ARB_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_grant  = 1'b1;
                    w_winner = ~r_last;
                end else if (bus.req0) begin
                    w_grant  = 1'b1;
                    w_winner = PORT_CPU;
                end else if (bus.req1) begin
                    w_grant  = 1'b1;
                    w_winner = PORT_DMA;
                end
                if (w_grant) begin
                    w_next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = ARB_ACK;
                end
            end
            ARB_ACK: begin
                w_next_state = ARB_IDLE;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant latches, wait counter and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_gnt   <= PORT_CPU;
            r_last  <= PORT_DMA;      // so the CPU wins the first tie
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_grant) begin
            r_gnt   <= w_winner;
            r_last  <= w_winner;
            r_we    <= w_winner ? bus.we1    : bus.we0;
            r_addr  <= w_winner ? bus.addr1  : bus.addr0;
            r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
            r_cnt   <= c_WAIT_M1;
        end else if (r_state == ARB_BUSY) begin
            if (r_cnt == '0) begin
                if (!r_we) begin
                    r_rdata <= bus.mem_rdata;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Memory bus is driven only in BUSY; address/data come straight from the latches.
    assign bus.mem_en    = (r_state == ARB_BUSY);
    assign bus.mem_we    = (r_state == ARB_BUSY) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.ack0   = (r_state == ARB_ACK) && (r_gnt == PORT_CPU);
    assign bus.ack1   = (r_state == ARB_ACK) && (r_gnt == PORT_DMA);
    assign bus.rdata  = r_rdata;
    assign bus.busy   = (r_state != ARB_IDLE);
    assign bus.gnt_id = r_gnt;

endmodule
`default_nettype wire
